// File: rtl/div3_frame_tx_if.sv
// Word-in / serial-out bundle for div3_frame_tx: valid/ready word handshake plus the
// registered serial frame outputs.
interface div3_frame_tx_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             frame;
  logic             last;
  logic [1:0]       residue;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, x, frame, last, residue, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, frame, last, residue, done
  );
endinterface

// File: rtl/div3_frame_tx.sv
// Serial frame transmitter: shifts a word out MSB-first and optionally appends a 2-bit
// check field that makes the whole frame divisible by 3.
module div3_frame_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter bit          APPEND_CHECK = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  div3_frame_tx_if.slave bus
);
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StData  = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;

  localparam int unsigned   CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [1:0]       chk_q, chk_d;
  logic [1:0]       residue_q, residue_d;
  logic [1:0]       chk_val;
  logic [2:0]       res_acc;
  logic             x_q, x_d;
  logic             frame_q, frame_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             accept;

  assign bus.din_ready = (state_q == StIdle) || last_q;
  assign accept        = bus.din_valid && bus.din_ready;

  // 2*r + x is at most 5, so a single conditional subtract reduces it mod 3.
  assign res_acc = {residue_q, 1'b0} + {2'b00, x_q};

  always_comb begin
    residue_d = residue_q;
    if (accept) begin
      residue_d = 2'd0;
    end else if (frame_q) begin
      residue_d = (res_acc >= 3'd3) ? 2'(res_acc - 3'd3) : res_acc[1:0];
    end
  end

  always_comb begin
    case (residue_d)
      2'd1:    chk_val = 2'd2;
      2'd2:    chk_val = 2'd1;
      default: chk_val = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    chk_d   = chk_q;
    x_d     = 1'b0;
    frame_d = 1'b0;
    last_d  = 1'b0;
    done_d  = last_q;
    if (accept) begin
      state_d = StData;
      cnt_d   = '0;
      x_d     = bus.din[WIDTH-1];
      shift_d = {bus.din[WIDTH-2:0], 1'b0};
      frame_d = 1'b1;
    end else begin
      case (state_q)
        StData: begin
          if (cnt_q == LastIdx) begin
            cnt_d = '0;
            if (APPEND_CHECK) begin
              // residue_d here is the residue of the data bits alone; freeze it.
              state_d = StCheck;
              chk_d   = chk_val;
              x_d     = chk_val[1];
              frame_d = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d   = cnt_q + CntW'(1);
            x_d     = shift_q[WIDTH-1];
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            frame_d = 1'b1;
            last_d  = !APPEND_CHECK && (cnt_d == LastIdx);
          end
        end
        StCheck: begin
          if (cnt_q == '0) begin
            cnt_d   = CntW'(1);
            x_d     = chk_q[0];
            frame_d = 1'b1;
            last_d  = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      chk_q     <= 2'd0;
      residue_q <= 2'd0;
      x_q       <= 1'b0;
      frame_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      chk_q     <= chk_d;
      residue_q <= residue_d;
      x_q       <= x_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.frame   = frame_q;
  assign bus.last    = last_q;
  assign bus.residue = residue_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_div3_frame_tx.sv
// Scoreboard bench for div3_frame_tx: one instance with the check field, one without.
module tb_div3_frame_tx;
  logic clk;
  logic rst_n;

  div3_frame_tx_if #(.WIDTH(8)) bus0 ();
  div3_frame_tx_if #(.WIDTH(8)) bus1 ();

  div3_frame_tx #(.WIDTH(8), .APPEND_CHECK(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  div3_frame_tx #(.WIDTH(8), .APPEND_CHECK(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic x;
    logic first;
    logic last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_done[2];
  int   mr[2];
  int   run[2];
  int   last_run[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Independent frame model: data bits MSB-first, then c = (3 - value mod 3) mod 3.
  task automatic push_frame(input int id, input logic [7:0] d, input bit append);
    exp_t       e;
    logic [1:0] c;
    int         n;
    logic [9:0] bits;
    c = 2'((3 - (int'(d) % 3)) % 3);
    if (append) begin
      bits = {d, c};
      n    = 10;
    end else begin
      bits = {2'b00, d};
      n    = 8;
    end
    for (int i = n - 1; i >= 0; i--) begin
      e.x     = bits[i];
      e.first = (i == n - 1);
      e.last  = (i == 0);
      if (id == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic monitor_step(input int id, input logic xv, input logic fv, input logic lv,
                              input logic dv, input logic [1:0] rv);
    exp_t e;
    int   n;
    logic nxt_done;
    n        = (id == 0) ? q0.size() : q1.size();
    nxt_done = 1'b0;
    check($sformatf("done%0d", id), dv, exp_done[id]);
    if (fv) begin
      check($sformatf("frame_unexp%0d", id), fv, (n != 0));
      if (n != 0) begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        if (e.first) mr[id] = 0;
        check($sformatf("x%0d", id), xv, e.x);
        check($sformatf("last%0d", id), lv, e.last);
        check($sformatf("residue%0d", id), rv, mr[id]);
        mr[id]   = (2 * mr[id] + int'(e.x)) % 3;
        nxt_done = e.last;
      end
      run[id]++;
    end else begin
      check($sformatf("idle_x%0d", id), xv, 1'b0);
      if (exp_done[id]) check($sformatf("res_done%0d", id), rv, mr[id]);
      if (n != 0) begin
        e = (id == 0) ? q0[0] : q1[0];
        if (!e.first) check($sformatf("gap%0d", id), fv, 1'b1);
      end
      if (run[id] != 0) last_run[id] = run[id];
      run[id] = 0;
    end
    exp_done[id] = nxt_done;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      monitor_step(0, bus0.x, bus0.frame, bus0.last, bus0.done, bus0.residue);
      monitor_step(1, bus1.x, bus1.frame, bus1.last, bus1.done, bus1.residue);
    end
  end

  // Called just after a negedge; leaves din_valid high once the word is accepted.
  task automatic send(input int id, input logic [7:0] d);
    bit   ok;
    logic rdy;
    ok = 1'b0;
    if (id == 0) begin
      bus0.din = d; bus0.din_valid = 1'b1;
    end else begin
      bus1.din = d; bus1.din_valid = 1'b1;
    end
    for (int i = 0; i < 100 && !ok; i++) begin
      rdy = (id == 0) ? bus0.din_ready : bus1.din_ready;
      if (rdy) begin
        @(posedge clk);
        push_frame(id, d, (id == 0));
        ok = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    check($sformatf("accept%0d", id), ok, 1'b1);
    @(negedge clk);
    #1;
    check($sformatf("latency%0d", id), (id == 0) ? bus0.frame : bus1.frame, 1'b1);
  endtask

  task automatic drain(input int id);
    int n;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      n = (id == 0) ? q0.size() : q1.size();
      if (n == 0 && !exp_done[id]) break;
    end
    check($sformatf("drain%0d", id), n, 0);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      exp_done[i] = 1'b0;
      mr[i]       = 0;
      run[i]      = 0;
      last_run[i] = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x"}, bus0.x, 1'b0);
    check({tag, "_frame"}, bus0.frame, 1'b0);
    check({tag, "_last"}, bus0.last, 1'b0);
    check({tag, "_done"}, bus0.done, 1'b0);
    check({tag, "_residue"}, bus0.residue, 2'd0);
    check({tag, "_ready"}, bus0.din_ready, 1'b1);
    check({tag, "_frame1"}, bus1.frame, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_model();
    rst_n          = 1'b0;
    bus0.din       = '0;
    bus0.din_valid = 1'b0;
    bus1.din       = '0;
    bus1.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Single frames: F3 -> 1111001100, 01 -> 0000000110, 05 -> 0000010101.
    send(0, 8'hF3);
    bus0.din_valid = 1'b0;
    drain(0);
    send(0, 8'h01);
    bus0.din_valid = 1'b0;
    drain(0);
    send(0, 8'h05);
    bus0.din_valid = 1'b0;
    drain(0);

    // Back-to-back with din_valid held: 20 gapless frame cycles.
    send(0, 8'h01);
    send(0, 8'h05);
    bus0.din_valid = 1'b0;
    drain(0);
    check("b2b_run", last_run[0], 20);

    // Asynchronous reset after 4 bits of AA.
    send(0, 8'hAA);
    bus0.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    send(0, 8'h03);
    bus0.din_valid = 1'b0;
    drain(0);

    // A valid pulse while busy must be ignored.
    send(0, 8'h05);
    bus0.din_valid = 1'b0;
    @(negedge clk);
    #1;
    bus0.din       = 8'hFF;
    bus0.din_valid = 1'b1;
    check("busy_ready", bus0.din_ready, 1'b0);
    @(negedge clk);
    #1;
    bus0.din_valid = 1'b0;
    drain(0);
    repeat (15) @(negedge clk);

    // No check field: 07 -> 00000111, residue 1 in the done cycle.
    @(negedge clk);
    #1;
    send(1, 8'h07);
    bus1.din_valid = 1'b0;
    drain(1);
    check("nochk_run", last_run[1], 8);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div3_frame_tx.md
# div3_frame_tx

Serial frame transmitter that is the sending end of the team's divisible-by-3 serial detector. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a single-bit line. Optionally it appends a 2-bit check field so that the whole transmitted frame, read as a binary number, is divisible by 3. A downstream divisible-by-3 detector reset at frame start therefore asserts its output on the frame's final bit.

## Interface
- WIDTH, 8, data bits per frame; legal range ≥ 2.
- APPEND_CHECK, 1, 1 = append 2 check bits after the data; 0 = data bits only.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  WIDTH  parallel word; sampled only on an accepted transfer.
- din_valid  in  1  word on din is valid.
- din_ready  out  1  block can accept a word this cycle (combinational from state).
- x  out  1  serial data bit, MSB first.
- frame  out  1  high in every cycle in which x carries a frame bit.
- last  out  1  high with the final bit of a frame.
- residue  out  2  registered value, mod 3, of all frame bits sent in completed cycles.
- done  out  1  one-cycle pulse in the cycle after a frame's last bit.

## Operation
- Frame length N = WIDTH + 2·APPEND_CHECK bits.
- States:
  - IDLE: frame=0, x=0, din_ready=1.
  - DATA: shift out din[WIDTH-1] down to din[0].
  - CHECK: 2 cycles, sending c[1] then c[0]. Only entered when APPEND_CHECK=1.
- Transfer occurs on a rising edge with din_valid && din_ready.
  - The block captures din into a shift register, clears residue to 0, and enters DATA.
- din_ready = (state==IDLE) || last. Accepting on the last-bit cycle gives gapless back-to-back frames.
- din_valid while din_ready=0 is ignored. din may change freely outside transfer edges.
- Residue update on each edge with frame=1: residue ← (2·residue + x) mod 3, using only states {0,1,2}.
- Check value: c = (3 − r_d) mod 3, where r_d is the residue of the WIDTH data bits.
  - Because 4 ≡ 1 (mod 3), value·4 + c ≡ 0 (mod 3).
  - c must be captured when DATA ends; CHECK bits must not alter it.
- After the last bit:
  - If a new word was accepted on that edge, go to DATA; residue restarts at 0.
  - Otherwise go to IDLE.
  - In either case, done=1 for the following cycle.
- Bit counter wraps per frame; no counter state carries between frames.

## Timing
- Reset values (while rst_n=0 and after release): state=IDLE, x=0, frame=0, last=0, done=0, residue=0, shift register=0. din_ready reads 1.
- Reset mid-frame aborts immediately and asynchronously. Outputs return to reset values. No done pulse. The partial frame is discarded.
- Latency: transfer at edge k → frame=1 and x=din[WIDTH-1] during cycle k+1.
- The last bit is in cycle k+N, with last=1. done=1 in cycle k+N+1.
- Throughput: one frame per N cycles when din_valid is held high.
- residue lags x by one cycle. In cycle k+N+1, residue equals the full-frame residue: 0 when APPEND_CHECK=1.
- x, frame, last, done, and residue are registered outputs (glitch-free).

## Test plan
- Reset then single word, WIDTH=8, APPEND_CHECK=1:
  - din=8'hF3 (243) → x = 1111001100 over cycles k+1..k+10.
  - last in cycle k+10, done in cycle k+11, residue=0 in cycle k+11.
- din=8'h01 → data r_d=1, c=2'b10, frame 0000000110 (6). din=8'h05 → r_d=2, c=2'b01, frame 0000010101 (21).
- Back-to-back: din_valid held high, words 8'h01 then 8'h05 → 20 consecutive frame=1 cycles with no gap.
  - done pulses in the first cycle of frame 2 and in the cycle after frame 2.
- Reset mid-frame: assert rst_n=0 after 4 bits of 8'hAA → x=0, frame=0, residue=0 at once, no done.
  - After release, din=8'h03 transmits 0000001100 cleanly.
- APPEND_CHECK=0, din=8'h07 → x = 00000111, frame 8 cycles, residue=1 in the done cycle.
- Handshake: din_valid pulsed while busy (mid-DATA) → ignored. The in-flight frame is unchanged and no extra frame is sent.
